// File: rtl/cp0_exc.sv
// CP0 exception/interrupt unit: SR, Cause, EPC and PRId registers plus the
// zero-latency take-exception decision for the M stage.
module cp0_exc #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4D50,
  parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        ValidM,
  input  logic [6:2]  ExcCode_M,
  input  logic [7:2]  HWInt,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  output logic        exp_out,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [7:2]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [7:2]  ip;
  logic [6:2]  exc_code;
  logic [31:0] epc_q;
  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_din;

  assign unused_din = ^{DIn[31:16], DIn[9:2]};

  assign int_req = ie & ~exl & (|(HWInt & im));
  assign exc_req = ValidM & ~exl & (ExcCode_M != 5'd0);

  // Gated by Reset so a live M-stage code cannot leak out while state is held clear.
  assign exp_out = (int_req | exc_req) & ~Reset;

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  assign EPC        = epc_q;

  always_comb begin
    DOut = 32'b0;
    case (A1)
      5'd12:   DOut = sr_word;
      5'd13:   DOut = cause_word;
      5'd14:   DOut = epc_q;
      5'd15:   DOut = PRID_VALUE;
      default: DOut = 32'b0;
    endcase
  end

  // Exception entry overrides any mtc0 in the same cycle; EXLClr beats an SR write for EXL.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc_q    <= EPC_RESET;
    end else begin
      ip <= HWInt;
      if (exp_out) begin
        exl      <= 1'b1;
        bd       <= BD_M;
        epc_q    <= BD_M ? (PC_M - 32'd4) : PC_M;
        exc_code <= int_req ? 5'd0 : ExcCode_M;
      end else begin
        if (WE && (A2 == 5'd12)) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (WE && (A2 == 5'd14)) begin
          epc_q <= DIn;
        end
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Directed self-checking bench for cp0_exc with hand-computed register values.
module tb_cp0_exc;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        ValidM;
  logic [6:2]  ExcCode_M;
  logic [7:2]  HWInt;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic        exp_out;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] val;

  cp0_exc dut (
    .Clk(Clk), .Reset(Reset), .PC_M(PC_M), .BD_M(BD_M), .ValidM(ValidM),
    .ExcCode_M(ExcCode_M), .HWInt(HWInt), .A1(A1), .A2(A2), .DIn(DIn),
    .WE(WE), .EXLClr(EXLClr), .exp_out(exp_out), .EPC(EPC), .DOut(DOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
    end
  endtask

  // One clock edge, leaving the bench 1ns past it so outputs are settled.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] idx, output logic [31:0] data);
    A1 = idx;
    #1;
    data = DOut;
  endtask

  initial begin
    Reset = 1'b1; PC_M = 32'h0; BD_M = 1'b0; ValidM = 1'b1; ExcCode_M = 5'd4;
    HWInt = 6'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; EXLClr = 1'b0;
    #3;
    checkOutput("exp_during_reset", {31'b0, exp_out}, 32'h0);
    readReg(5'd14, val); checkOutput("epc_during_reset", val, 32'h0000_3000);
    ValidM = 1'b0; ExcCode_M = 5'd0;
    #8 Reset = 1'b0;
    #1;

    readReg(5'd12, val); checkOutput("reset_sr", val, 32'h0);
    readReg(5'd13, val); checkOutput("reset_cause", val, 32'h0);
    readReg(5'd14, val); checkOutput("reset_epc", val, 32'h0000_3000);
    readReg(5'd15, val); checkOutput("prid", val, 32'h0000_4D50);
    readReg(5'd7, val);  checkOutput("other_idx", val, 32'h0);
    checkOutput("reset_exp", {31'b0, exp_out}, 32'h0);
    checkOutput("reset_epc_port", EPC, 32'h0000_3000);

    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    applyStimulus();
    WE = 1'b0;
    readReg(5'd12, val); checkOutput("mtc0_sr", val, 32'h0000_0401);

    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    applyStimulus();
    WE = 1'b0;
    readReg(5'd13, val); checkOutput("cause_write_ignored", val, 32'h0);

    HWInt = 6'b000001; PC_M = 32'h3010;
    #1 checkOutput("int_exp_same_cycle", {31'b0, exp_out}, 32'h1);
    applyStimulus();
    readReg(5'd14, val); checkOutput("int_epc", val, 32'h0000_3010);
    readReg(5'd13, val); checkOutput("int_cause", val, 32'h0000_0400);
    readReg(5'd12, val); checkOutput("int_sr_exl", val, 32'h0000_0403);
    checkOutput("int_exp_cleared", {31'b0, exp_out}, 32'h0);

    ValidM = 1'b1; ExcCode_M = 5'd4;
    #1 checkOutput("no_nesting", {31'b0, exp_out}, 32'h0);
    ValidM = 1'b0; ExcCode_M = 5'd0;

    HWInt = 6'b0; EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;
    readReg(5'd12, val); checkOutput("eret_sr", val, 32'h0000_0401);

    ExcCode_M = 5'd4; ValidM = 1'b1; BD_M = 1'b1; PC_M = 32'h3024;
    #1 checkOutput("exc_exp", {31'b0, exp_out}, 32'h1);
    applyStimulus();
    readReg(5'd14, val); checkOutput("exc_epc_bd", val, 32'h0000_3020);
    readReg(5'd13, val); checkOutput("exc_cause", val, 32'h8000_0010);
    ExcCode_M = 5'd0; ValidM = 1'b0; BD_M = 1'b0; EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;
    ExcCode_M = 5'd4; ValidM = 1'b0;
    #1 checkOutput("bubble_no_exc", {31'b0, exp_out}, 32'h0);

    ExcCode_M = 5'd12; ValidM = 1'b1; BD_M = 1'b1; PC_M = 32'h0;
    applyStimulus();
    readReg(5'd14, val); checkOutput("epc_wrap", val, 32'hFFFF_FFFC);
    readReg(5'd13, val); checkOutput("wrap_cause", val, 32'h8000_0030);
    ExcCode_M = 5'd0; ValidM = 1'b0; BD_M = 1'b0; EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;

    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
    applyStimulus();
    WE = 1'b0; EXLClr = 1'b0;
    readReg(5'd12, val); checkOutput("exlclr_wins", val, 32'h0000_0401);

    HWInt = 6'b000001; ValidM = 1'b1; ExcCode_M = 5'd10; PC_M = 32'h3040;
    #1 checkOutput("both_exp", {31'b0, exp_out}, 32'h1);
    applyStimulus();
    ValidM = 1'b0; ExcCode_M = 5'd0;
    readReg(5'd13, val); checkOutput("int_priority_cause", val, 32'h0000_0400);
    readReg(5'd14, val); checkOutput("both_epc", val, 32'h0000_3040);
    EXLClr = 1'b1;
    #1 checkOutput("exl_blocks_int", {31'b0, exp_out}, 32'h0);
    applyStimulus();
    EXLClr = 1'b0;
    #1 checkOutput("int_reraise", {31'b0, exp_out}, 32'h1);

    PC_M = 32'h3008; WE = 1'b1; A2 = 5'd14; DIn = 32'h4000;
    applyStimulus();
    WE = 1'b0;
    readReg(5'd14, val); checkOutput("mtc0_dropped", val, 32'h0000_3008);
    HWInt = 6'b0; EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h4000;
    applyStimulus();
    WE = 1'b0;
    readReg(5'd14, val); checkOutput("mtc0_epc", val, 32'h0000_4000);

    HWInt = 6'b000001; PC_M = 32'h3050;
    applyStimulus();
    readReg(5'd12, val); checkOutput("pre_reset_exl", val, 32'h0000_0403);
    Reset = 1'b1;
    #1;
    checkOutput("async_exp", {31'b0, exp_out}, 32'h0);
    readReg(5'd12, val); checkOutput("async_sr", val, 32'h0);
    readReg(5'd14, val); checkOutput("async_epc", val, 32'h0000_3000);
    readReg(5'd13, val); checkOutput("async_cause", val, 32'h0);
    Reset = 1'b0; HWInt = 6'b0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
